hpb_wr_sched: RTL and testbench
===============================

Name: hpb_wr_sched

Overview:
- Host-side write scheduler sitting between the host parameter bus and the symbol-RAM control block.
- Buffers host configuration writes in a small FIFO.
- Presents writes one at a time on the RAM write-request interface and holds each until the RAM control block grants it; grants occur only in cycles with no feed-decoder read.
- Tracks completed writes and flags write starvation caused by sustained decoder read traffic.

Parameters:
- RAM_WIDTH, 64, width of one symbol-RAM word; must be a multiple of 8.
- FIFO_DEPTH, 4, number of buffered host writes; power of two, ≥2.
- STARVE_LIMIT, 255, consecutive ungranted request cycles before the starve flag sets; range 1..65535.

Ports:
- clk  in  1  core clock
- reset_n  in  1  active-low reset, asynchronous assert
- host_wr_valid  in  1  host write offered
- host_wr_ready  out  1  scheduler can accept a write
- host_wr_addr  in  14  symbol-RAM word address
- host_wr_data  in  RAM_WIDTH  write data
- host_wr_be  in  RAM_WIDTH/8  byte enables
- hpb_wr_req  out  1  write request to RAM control
- hpb_wr_addr  out  14  request address
- hpb_wr_data  out  RAM_WIDTH  request data
- hpb_wr_en  out  RAM_WIDTH/8  request byte enables
- rcb_wr_done  in  1  grant/complete, same-cycle with write
- sef_read  in  1  decoder read strobe (observed only)
- starve_clr  in  1  clears sched_starve
- sched_busy  out  1  FIFO non-empty or request in flight
- sched_starve  out  1  sticky starvation flag
- wr_count  out  16  completed writes, wrapping

Behaviour:
- Reset (async, reset_n low): FIFO empty; state IDLE; all outputs 0 except host_wr_ready, which is 1.
- FIFO:
  - Push on host_wr_valid && host_wr_ready.
  - host_wr_ready = !full, from registered occupancy; no push when full even if a pop occurs that cycle.
  - A write with host_wr_be == 0 is accepted but not stored and not counted.
- FSM states: IDLE, REQ, RELEASE.
  - IDLE: if FIFO non-empty, register head into hpb_wr_addr/data/en; next cycle hpb_wr_req=1, state REQ. A push into an empty FIFO reaches hpb_wr_req after 2 cycles.
  - REQ:
    - hpb_wr_req and the payload are held stable.
    - On rcb_wr_done=1: pop head, increment wr_count (wraps 0xFFFF→0), go RELEASE.
  - RELEASE:
    - hpb_wr_req=0 for exactly one cycle; this is required so RAM control re-arms.
    - If FIFO non-empty, load the next head and go REQ; otherwise go IDLE.
  - Peak throughput: one write per 2 cycles.
- rcb_wr_done outside REQ: ignored; not counted.
- Starvation:
  - A 16-bit counter increments each REQ cycle without rcb_wr_done and zeroes on grant or on leaving REQ.
  - When the counter reaches STARVE_LIMIT, sched_starve sets.
  - sched_starve is cleared by starve_clr; if set and clear occur in the same cycle, set wins.
  - The request is never abandoned.
- sef_read is used only to qualify starvation: cycles with sef_read=0 and no grant still count. Such cycles indicate a protocol fault and are counted regardless.
- sched_busy = FIFO non-empty || state != IDLE.
- Reset mid-REQ: request dropped, FIFO contents lost, hpb_wr_req low asynchronously.

Optional Feature:
- Macro: HPB_WR_MERGE_EN.
- Defined:
  - A push whose address equals the newest FIFO entry's address merges into that entry instead of allocating: per-byte, new data overwrites where host_wr_be is set, and enables OR together.
  - Merge is allowed only if that entry is not the head currently loaded into REQ/RELEASE.
  - Merge is permitted when the FIFO is full, and host_wr_ready stays 1 for a matching address.
- Undefined: every write allocates its own entry; no address compare logic.

Test Plan:
- Single write addr 0x0123, data 0xDEADBEEF_CAFEF00D, be 0xFF, sef_read=0, rcb_wr_done looped from req → hpb_wr_req high 2 cycles after push for 1 cycle, then low 1 cycle; wr_count=1; sched_busy falls after RELEASE.
- Back-to-back 4 writes filling FIFO (depth 4) → host_wr_ready=0 after 4th push; requests issue every 2 cycles; wr_count=4; ready returns 1 cycle after first pop.
- Hold rcb_wr_done=0 for 300 cycles with STARVE_LIMIT=255 → sched_starve=1 at the 255th ungranted cycle; payload stable throughout; starve_clr pulse afterward → flag 0; grant then completes the write.
- Assert reset_n low mid-REQ with 3 entries queued → hpb_wr_req=0 immediately; after release, sched_busy=0, wr_count=0, host_wr_ready=1.
- Push with be=0 → accepted, no hpb_wr_req, wr_count unchanged.
- With HPB_WR_MERGE_EN: two pushes to addr 0x0010 (be 0x0F data lanes 0x11.., then be 0xF0 data 0x22..) while head busy → single request, hpb_wr_en=0xFF, combined data; wr_count increments by 1.

Source files
------------

// File: rtl/hpb_wr_sched.sv
// Host parameter bus write scheduler: buffers host writes and issues them one at a time to RAM control.
// Optional HPB_WR_MERGE_EN: same-address pushes merge into the newest FIFO entry that is not yet loaded.
module hpb_wr_sched #(
    parameter int RAM_WIDTH    = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   host_wr_valid,
    output logic                   host_wr_ready,
    input  logic [13:0]            host_wr_addr,
    input  logic [RAM_WIDTH-1:0]   host_wr_data,
    input  logic [RAM_WIDTH/8-1:0] host_wr_be,
    output logic                   hpb_wr_req,
    output logic [13:0]            hpb_wr_addr,
    output logic [RAM_WIDTH-1:0]   hpb_wr_data,
    output logic [RAM_WIDTH/8-1:0] hpb_wr_en,
    input  logic                   rcb_wr_done,
    input  logic                   sef_read,
    input  logic                   starve_clr,
    output logic                   sched_busy,
    output logic                   sched_starve,
    output logic [15:0]            wr_count
);
    // state   | meaning
    // IDLE    | nothing loaded; loads FIFO head when available
    // REQ     | request asserted, payload held until rcb_wr_done
    // RELEASE | one-cycle request gap so RAM control re-arms; loads next head
    localparam int BE_W  = RAM_WIDTH / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE} state_t;
    state_t state_q, state_d;

    logic [13:0]          mem_addr_q [FIFO_DEPTH];
    logic [RAM_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [BE_W-1:0]      mem_be_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [13:0]          addr_q;
    logic [RAM_WIDTH-1:0] data_q;
    logic [BE_W-1:0]      en_q;
    logic [15:0]          wr_count_q;
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic                 starve_q, starve_d;

    logic empty, full, merge_hit, push_acc, do_store, pop, load;
    logic stall_read, stall_fault, stall, starve_set;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop      = (state_q == ST_REQ) && rcb_wr_done;
    assign push_acc = host_wr_valid && host_wr_ready;
    assign do_store = push_acc && !merge_hit && (host_wr_be != '0);

`ifdef HPB_WR_MERGE_EN
    logic [PTR_W-1:0] newest_idx;
    assign newest_idx = wr_ptr_q - PTR_W'(1);
    // With a single entry, that entry is the head being loaded or already in flight.
    assign merge_hit  = (count_q >= CNT_W'(2)) && (mem_addr_q[newest_idx] == host_wr_addr);
`else
    assign merge_hit  = 1'b0;
`endif

    assign host_wr_ready = !full || merge_hit;

    always_ff @(posedge clk) begin
        if (do_store) begin
            mem_addr_q[wr_ptr_q] <= host_wr_addr;
            mem_data_q[wr_ptr_q] <= host_wr_data;
            mem_be_q[wr_ptr_q]   <= host_wr_be;
        end
`ifdef HPB_WR_MERGE_EN
        if (push_acc && merge_hit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (host_wr_be[b]) mem_data_q[newest_idx][b*8 +: 8] <= host_wr_data[b*8 +: 8];
            end
            mem_be_q[newest_idx] <= mem_be_q[newest_idx] | host_wr_be;
        end
`endif
    end

    always_comb begin
        count_d = count_q;
        if (do_store && !pop)      count_d = count_q + CNT_W'(1);
        else if (!do_store && pop) count_d = count_q - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rcb_wr_done) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                load    = !empty;
                state_d = empty ? ST_IDLE : ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ungranted cycles without a decoder read are a protocol fault but still count.
    assign stall_read  = (state_q == ST_REQ) && !rcb_wr_done && sef_read;
    assign stall_fault = (state_q == ST_REQ) && !rcb_wr_done && !sef_read;
    assign stall       = stall_read || stall_fault;
    assign starve_set  = stall && (stall_cnt_q == 16'(STARVE_LIMIT - 1));

    always_comb begin
        stall_cnt_d = '0;
        if (stall) stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
        starve_d = starve_q;
        if (starve_set)      starve_d = 1'b1;
        else if (starve_clr) starve_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            en_q        <= '0;
            wr_count_q  <= '0;
            stall_cnt_q <= '0;
            starve_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            starve_q    <= starve_d;
            if (do_store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (load) begin
                addr_q <= mem_addr_q[rd_ptr_q];
                data_q <= mem_data_q[rd_ptr_q];
                en_q   <= mem_be_q[rd_ptr_q];
            end
        end
    end

    assign hpb_wr_req   = (state_q == ST_REQ);
    assign hpb_wr_addr  = addr_q;
    assign hpb_wr_data  = data_q;
    assign hpb_wr_en    = en_q;
    assign sched_busy   = !empty || (state_q != ST_IDLE);
    assign sched_starve = starve_q;
    assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_hpb_wr_sched.sv
// Self-checking bench for hpb_wr_sched: directed vector table, starvation/reset sequences,
// and randomized traffic against a queue-based transaction model.
module tb_hpb_wr_sched;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_wr_valid, host_wr_ready;
    logic [13:0] host_wr_addr;
    logic [63:0] host_wr_data;
    logic [7:0]  host_wr_be;
    logic        hpb_wr_req;
    logic [13:0] hpb_wr_addr;
    logic [63:0] hpb_wr_data;
    logic [7:0]  hpb_wr_en;
    logic        rcb_wr_done, sef_read, starve_clr;
    logic        sched_busy, sched_starve;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    hpb_wr_sched #(.RAM_WIDTH(64), .FIFO_DEPTH(4), .STARVE_LIMIT(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .host_wr_be(host_wr_be),
        .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
        .hpb_wr_en(hpb_wr_en), .rcb_wr_done(rcb_wr_done), .sef_read(sef_read),
        .starve_clr(starve_clr), .sched_busy(sched_busy), .sched_starve(sched_starve),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [13:0] a;
        logic [63:0] d;
        logic [7:0]  be;
        logic        done;
        logic        e_req, e_rdy, e_busy;
        logic [15:0] e_cnt;
        logic [13:0] e_addr;
        logic [63:0] e_data;
        logic [7:0]  e_en;
    } vec_t;

    typedef struct {
        logic [13:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } wr_t;

    vec_t tbl[$];
    wr_t  mq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [13:0] a, input logic [63:0] d,
                         input logic [7:0] be, input logic done);
        host_wr_valid = v;
        host_wr_addr  = a;
        host_wr_data  = d;
        host_wr_be    = be;
        rcb_wr_done   = done;
    endtask

    function automatic vec_t mk(input logic v, input logic [13:0] a, input logic [63:0] d,
                                input logic [7:0] be, input logic done, input logic e_req,
                                input logic e_rdy, input logic e_busy, input logic [15:0] e_cnt,
                                input logic [13:0] e_addr, input logic [63:0] e_data,
                                input logic [7:0] e_en);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.be = be; r.done = done;
        r.e_req = e_req; r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_cnt = e_cnt;
        r.e_addr = e_addr; r.e_data = e_data; r.e_en = e_en;
        return r;
    endfunction

    localparam logic [63:0] DW = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] DA = 64'hAAAA_AAAA_0000_0001;
    localparam logic [63:0] DB = 64'hBBBB_BBBB_0000_0002;
    localparam logic [63:0] DC = 64'hCCCC_CCCC_0000_0003;
    localparam logic [63:0] DD = 64'hDDDD_DDDD_0000_0004;
    localparam logic [63:0] DE = 64'hEEEE_EEEE_0000_0005;

    initial begin
        int gap;
        logic prev_grant, grant, acc;
        logic [15:0] mcnt;

        reset_n = 1'b0;
        starve_clr = 1'b0;
        sef_read = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0);

        #12;
        check("rst_req", hpb_wr_req, 1'b0);
        check("rst_ready", host_wr_ready, 1'b1);
        check("rst_busy", sched_busy, 1'b0);
        check("rst_starve", sched_starve, 1'b0);
        check("rst_count", wr_count, 16'd0);
        check("rst_payload", {hpb_wr_addr, hpb_wr_en}, '0);
        check("rst_data", hpb_wr_data, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single write, 4-deep fill with a rejected 5th push, be=0 push, stray done.
        tbl.push_back(mk(1, 14'h0123, DW, 8'hFF, 0,  0, 1, 1, 16'd0, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 0,  1, 1, 1, 16'd0, 14'h0123, DW, 8'hFF));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 1,  0, 1, 1, 16'd1, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 0,  0, 1, 0, 16'd1, '0, '0, '0));
        tbl.push_back(mk(1, 14'h0200, DA, 8'hFF, 0,  0, 1, 1, 16'd1, '0, '0, '0));
        tbl.push_back(mk(1, 14'h0201, DB, 8'h0F, 0,  1, 1, 1, 16'd1, 14'h0200, DA, 8'hFF));
        tbl.push_back(mk(1, 14'h0202, DC, 8'hF0, 0,  1, 1, 1, 16'd1, 14'h0200, DA, 8'hFF));
        tbl.push_back(mk(1, 14'h0203, DD, 8'h3C, 0,  1, 0, 1, 16'd1, 14'h0200, DA, 8'hFF));
        tbl.push_back(mk(1, 14'h0204, DE, 8'hFF, 1,  0, 1, 1, 16'd2, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 0,  1, 1, 1, 16'd2, 14'h0201, DB, 8'h0F));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 1,  0, 1, 1, 16'd3, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 0,  1, 1, 1, 16'd3, 14'h0202, DC, 8'hF0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 1,  0, 1, 1, 16'd4, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 0,  1, 1, 1, 16'd4, 14'h0203, DD, 8'h3C));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 1,  0, 1, 1, 16'd5, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 0,  0, 1, 0, 16'd5, '0, '0, '0));
        tbl.push_back(mk(1, 14'h0300, DW, 8'h00, 0,  0, 1, 0, 16'd5, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 0,  0, 1, 0, 16'd5, '0, '0, '0));
        tbl.push_back(mk(0, 14'h0000, 0,  8'h00, 1,  0, 1, 0, 16'd5, '0, '0, '0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].done);
            step();
            check($sformatf("vec%0d_req", i), hpb_wr_req, tbl[i].e_req);
            check($sformatf("vec%0d_ready", i), host_wr_ready, tbl[i].e_rdy);
            check($sformatf("vec%0d_busy", i), sched_busy, tbl[i].e_busy);
            check($sformatf("vec%0d_count", i), wr_count, tbl[i].e_cnt);
            if (tbl[i].e_req) begin
                check($sformatf("vec%0d_addr", i), hpb_wr_addr, tbl[i].e_addr);
                check($sformatf("vec%0d_data", i), hpb_wr_data, tbl[i].e_data);
                check($sformatf("vec%0d_en", i), hpb_wr_en, tbl[i].e_en);
            end
        end
        drive(1'b0, '0, '0, '0, 1'b0);

        // Starvation: flag sets on the 255th ungranted cycle, clear pulse, then grant.
        drive(1'b1, 14'h03AB, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        check("starve_req_up", hpb_wr_req, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            sef_read = 1'($urandom);
            step();
            check($sformatf("starve_flag_k%0d", k), sched_starve, (k >= 255));
            check("starve_addr_hold", {hpb_wr_req, hpb_wr_addr}, {1'b1, 14'h03AB});
            check("starve_data_hold", hpb_wr_data, 64'h0123_4567_89AB_CDEF);
        end
        starve_clr = 1'b1;
        step();
        starve_clr = 1'b0;
        check("starve_cleared", sched_starve, 1'b0);
        check("starve_still_req", hpb_wr_req, 1'b1);
        rcb_wr_done = 1'b1;
        step();
        rcb_wr_done = 1'b0;
        check("starve_grant_req", hpb_wr_req, 1'b0);
        check("starve_grant_count", wr_count, 16'd6);

        // Set and clear in the same cycle: set wins.
        drive(1'b1, 14'h03AC, 64'h5555_0000_5555_0000, 8'hFF, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        for (int k = 1; k <= 254; k++) step();
        check("setwin_pre", sched_starve, 1'b0);
        starve_clr = 1'b1;
        step();
        starve_clr = 1'b0;
        check("setwin_flag", sched_starve, 1'b1);
        starve_clr = 1'b1;
        step();
        starve_clr = 1'b0;
        check("setwin_cleared", sched_starve, 1'b0);
        rcb_wr_done = 1'b1;
        step();
        rcb_wr_done = 1'b0;
        check("setwin_count", wr_count, 16'd7);

        // Reset in the middle of REQ with three entries queued.
        drive(1'b1, 14'h0400, 64'h1, 8'hFF, 1'b0);
        step();
        drive(1'b1, 14'h0401, 64'h2, 8'hFF, 1'b0);
        step();
        drive(1'b1, 14'h0402, 64'h3, 8'hFF, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        check("midrst_req_before", hpb_wr_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_req_async", hpb_wr_req, 1'b0);
        check("midrst_busy", sched_busy, 1'b0);
        check("midrst_count", wr_count, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        step();
        check("postrst_busy", sched_busy, 1'b0);
        check("postrst_ready", host_wr_ready, 1'b1);
        check("postrst_req", hpb_wr_req, 1'b0);
        check("postrst_count", wr_count, 16'd0);
        mcnt = 16'd0;

`ifdef HPB_WR_MERGE_EN
        // Two pushes to the same address behind a busy head collapse into one request.
        drive(1'b1, 14'h0500, 64'h5, 8'hFF, 1'b0);
        step();
        drive(1'b1, 14'h0010, 64'h1111_1111_1111_1111, 8'h0F, 1'b0);
        step();
        drive(1'b1, 14'h0010, 64'h2222_2222_2222_2222, 8'hF0, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        check("merge_head_addr", hpb_wr_addr, 14'h0500);
        rcb_wr_done = 1'b1;
        step();
        rcb_wr_done = 1'b0;
        step();
        check("merge_req", {hpb_wr_req, hpb_wr_addr}, {1'b1, 14'h0010});
        check("merge_en", hpb_wr_en, 8'hFF);
        check("merge_data", hpb_wr_data, 64'h2222_2222_1111_1111);
        rcb_wr_done = 1'b1;
        step();
        rcb_wr_done = 1'b0;
        step();
        check("merge_count", wr_count, 16'd2);
        check("merge_idle", {hpb_wr_req, sched_busy}, 2'b00);
        mcnt = 16'd2;
`endif

        // Randomized traffic against an in-order transaction model.
        gap = 0;
        prev_grant = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            host_wr_valid = ($urandom_range(0, 9) < 6);
            host_wr_addr  = 14'(n * 7 + 1);
            host_wr_data  = {$urandom, $urandom};
            host_wr_be    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rcb_wr_done   = ($urandom_range(0, 9) < 4);
            sef_read      = 1'($urandom);
            #1;
            check("rnd_ready", host_wr_ready, (mq.size() < 4));
            check("rnd_count", wr_count, mcnt);
            check("rnd_starve", sched_starve, 1'b0);
            if (mq.size() != 0) check("rnd_busy", sched_busy, 1'b1);
            if (prev_grant) check("rnd_release_gap", hpb_wr_req, 1'b0);
            if (hpb_wr_req) begin
                if (mq.size() == 0) check("rnd_req_empty", hpb_wr_req, 1'b0);
                else check("rnd_payload", {hpb_wr_addr, hpb_wr_en, hpb_wr_data},
                           {mq[0].a, mq[0].be, mq[0].d});
            end
            gap = (mq.size() != 0 && !hpb_wr_req) ? gap + 1 : 0;
            check("rnd_latency", (gap <= 1), 1'b1);
            grant = hpb_wr_req && rcb_wr_done;
            acc   = host_wr_valid && (mq.size() < 4);
            prev_grant = grant;
            step();
            if (grant && mq.size() != 0) begin
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end
            if (acc && host_wr_be != 8'h00)
                mq.push_back('{a: host_wr_addr, d: host_wr_data, be: host_wr_be});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
